// File: rtl/vga_hsync_monitor_if.sv
// Port bundle for the hsync monitor: raw hsync in, measured line timing out.
// The monitor uses the slave modport; whatever drives hsync and consumes the timing uses master.
interface vga_hsync_monitor_if #(
  parameter int CNT_W = 12
) ();
  logic             hsync_in;
  logic [CNT_W-1:0] line_period;
  logic [CNT_W-1:0] pulse_width;
  logic             sync_pol;
  logic             meas_valid;
  logic             locked;
  logic             line_start;
  logic             no_signal;

  modport master (
    output hsync_in,
    input  line_period, pulse_width, sync_pol, meas_valid, locked, line_start, no_signal
  );

  modport slave (
    input  hsync_in,
    output line_period, pulse_width, sync_pol, meas_valid, locked, line_start, no_signal
  );
endinterface

// File: rtl/vga_hsync_monitor.sv
// Measures the incoming hsync period, pulse width and polarity, declares lock, and strobes line starts.
// Optional VGA_HSYNC_MON_DEGLITCH_EN adds a 3-sample stability filter after the synchronizer.
module vga_hsync_monitor #(
  parameter int CNT_W      = 12,
  parameter int LOCK_LINES = 4,
  parameter int TOL        = 2
) (
  input  logic               clk,
  input  logic               rst,
  vga_hsync_monitor_if.slave mon
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               MW      = $clog2(LOCK_LINES + 1);
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_LINES);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic             pol;
  } meas_t;

  // ---------------- input path ----------------
  logic sync_q1, sync_q2, lvl, lvl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      lvl_d   <= 1'b0;
    end else begin
      sync_q1 <= mon.hsync_in;
      sync_q2 <= sync_q1;
      lvl_d   <= lvl;
    end
  end

`ifdef VGA_HSYNC_MON_DEGLITCH_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[0], sync_q2};
  end

  // lvl_d doubles as the filter's held level; it only moves after three equal samples.
  assign lvl = (sync_q2 == hist[0] && hist[0] == hist[1]) ? sync_q2 : lvl_d;
`else
  assign lvl = sync_q2;
`endif

  logic rise, fall;
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // ---------------- phase FSM ----------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_cnt, high_nxt, low_cnt, low_nxt;
  logic             publish, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_RISE;
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      high_cnt <= high_nxt;
      low_cnt  <= low_nxt;
    end
  end

  // Timeout fires on the cycle a counter would step onto its saturation value.
  always_comb begin
    state_nxt = state;
    high_nxt  = high_cnt;
    low_nxt   = low_cnt;
    publish   = 1'b0;
    timeout   = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (rise) begin
          state_nxt = MEAS_HIGH;
          high_nxt  = CNT_W'(1);
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          state_nxt = MEAS_LOW;
          low_nxt   = CNT_W'(1);
        end else if (high_cnt == CNT_MAX - 1'b1) begin
          timeout   = 1'b1;
          state_nxt = WAIT_RISE;
          high_nxt  = CNT_MAX;
        end else begin
          high_nxt = high_cnt + 1'b1;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          publish   = 1'b1;
          state_nxt = MEAS_HIGH;
          high_nxt  = CNT_W'(1);
        end else if (low_cnt == CNT_MAX - 1'b1) begin
          timeout   = 1'b1;
          state_nxt = WAIT_RISE;
          low_nxt   = CNT_MAX;
        end else begin
          low_nxt = low_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_RISE;
    endcase
  end

  // ---------------- measurement / lock ----------------
  meas_t            meas, meas_new;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] diff;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             prev_vld, match;
  logic             meas_valid, locked, line_start, no_signal;

  always_comb begin
    sum            = {1'b0, high_cnt} + {1'b0, low_cnt};
    meas_new.period = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    meas_new.pol    = (high_cnt < low_cnt);
    meas_new.width  = meas_new.pol ? high_cnt : low_cnt;
    diff  = (meas_new.period >= meas.period) ? meas_new.period - meas.period
                                             : meas.period - meas_new.period;
    match = prev_vld && (diff <= CNT_W'(TOL)) && (meas_new.pol == meas.pol);
    if (!match)                 match_nxt = '0;
    else if (match_cnt == LOCK_N) match_nxt = match_cnt;
    else                        match_nxt = match_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas       <= '0;
      prev_vld   <= 1'b0;
      match_cnt  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      line_start <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= publish;
      line_start <= locked && (meas.pol ? rise : fall);
      if (timeout) begin
        prev_vld  <= 1'b0;
        match_cnt <= '0;
        locked    <= 1'b0;
        no_signal <= 1'b1;
      end else if (publish) begin
        meas      <= meas_new;
        prev_vld  <= 1'b1;
        match_cnt <= match_nxt;
        locked    <= (match_nxt == LOCK_N);
        no_signal <= 1'b0;
      end
    end
  end

  assign mon.line_period = meas.period;
  assign mon.pulse_width = meas.width;
  assign mon.sync_pol    = meas.pol;
  assign mon.meas_valid  = meas_valid;
  assign mon.locked      = locked;
  assign mon.line_start  = line_start;
  assign mon.no_signal   = no_signal;
endmodule

// File: tb/tb_vga_hsync_monitor.sv
// Directed bench for vga_hsync_monitor: clk-synchronous hsync waveforms with hand-computed expectations.
module tb_vga_hsync_monitor;
  localparam int CNT_W = 12;
`ifdef VGA_HSYNC_MON_DEGLITCH_EN
  localparam int LAT   = 5;
  localparam int GL_MV = 2;
  localparam int GL_LO = 0;
`else
  localparam int LAT   = 3;
  localparam int GL_MV = 3;
  localparam int GL_LO = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_hsync_monitor_if #(.CNT_W(CNT_W)) mif ();

  vga_hsync_monitor #(.CNT_W(CNT_W), .LOCK_LINES(4), .TOL(2)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mif)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  int mv_total = 0, lo_total = 0, ls_total = 0, lock_rise_at = 0;
  int ls_cyc = 0, ns_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  int mv0 = 0, lo0 = 0, ls0 = 0;
  logic lk_prev = 1'b0, ns_prev = 1'b0;
  int jit [6] = '{1058, 1056, 1054, 1056, 1058, 1056};

  always @(posedge clk) cyc <= cyc + 1;

  // event recorder: strobes are tallied here, checks read the tallies
  always @(negedge clk) begin
    lk_prev <= mif.locked;
    ns_prev <= mif.no_signal;
    if (!rst) begin
      if (mif.meas_valid) begin
        mv_total <= mv_total + 1;
        if (!mif.locked) lo_total <= lo_total + 1;
        if (mif.locked && !lk_prev) lock_rise_at <= mv_total + 1;
      end
      if (mif.line_start) begin
        ls_total <= ls_total + 1;
        ls_cyc   <= cyc;
      end
      if (mif.no_signal && !ns_prev) ns_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (v && !mif.hsync_in) rise_cyc = cyc;
      if (!v && mif.hsync_in) fall_cyc = cyc;
      mif.hsync_in = v;
    end
  endtask

  task automatic line(input int per, input int pw, input logic pol);
    drive(pol, pw);
    drive(~pol, per - pw);
  endtask

  task automatic snap();
    mv0 = mv_total;
    lo0 = lo_total;
    ls0 = ls_total;
  endtask

  initial begin
    mif.hsync_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", mif.line_period, 0);
    chk("rst_width",  mif.pulse_width, 0);
    chk("rst_flags",  {mif.sync_pol, mif.meas_valid, mif.locked, mif.line_start, mif.no_signal}, 0);
    rst = 1'b0;

    // nominal timing, active-low sync
    snap();
    repeat (8) line(1056, 128, 1'b0);
    chk("nom_mv",      mv_total - mv0, 7);
    chk("nom_period",  mif.line_period, 1056);
    chk("nom_width",   mif.pulse_width, 128);
    chk("nom_pol",     mif.sync_pol, 0);
    chk("nom_locked",  mif.locked, 1);
    chk("nom_lock_at", lock_rise_at - mv0, 5);
    chk("nom_ls",      ls_total - ls0, 2);
    chk("nom_ls_lat",  ls_cyc - fall_cyc, LAT);

    // jitter within tolerance
    snap();
    foreach (jit[i]) line(jit[i], 128, 1'b0);
    chk("jit2_mv",     mv_total - mv0, 6);
    chk("jit2_lo",     lo_total - lo0, 0);
    chk("jit2_locked", mif.locked, 1);
    chk("jit2_period", mif.line_period, 1058);

    // step of 3 clocks breaks lock
    snap();
    line(1059, 128, 1'b0);
    line(1056, 128, 1'b0);
    chk("jit3_locked", mif.locked, 0);
    chk("jit3_period", mif.line_period, 1059);
    chk("jit3_lo",     lo_total - lo0, 1);
    repeat (6) line(1056, 128, 1'b0);
    chk("relock_1056", mif.locked, 1);

    // period change to 1060 and relock
    snap();
    repeat (6) line(1060, 128, 1'b0);
    chk("p1060_mv",      mv_total - mv0, 6);
    chk("p1060_lo",      lo_total - lo0, 4);
    chk("p1060_lock_at", lock_rise_at - mv0, 6);
    chk("p1060_locked",  mif.locked, 1);
    chk("p1060_period",  mif.line_period, 1060);

    // hsync stuck low
    snap();
    drive(1'b0, 5000);
    chk("to_ns_lat", ns_cyc - fall_cyc, LAT + 4094);
    chk("to_nosig",  mif.no_signal, 1);
    chk("to_locked", mif.locked, 0);
    chk("to_period", mif.line_period, 1060);
    chk("to_width",  mif.pulse_width, 128);
    chk("to_mv",     mv_total - mv0, 0);
    snap();
    repeat (2) line(1056, 128, 1'b0);
    chk("res_nosig",  mif.no_signal, 0);
    chk("res_mv",     mv_total - mv0, 1);
    chk("res_period", mif.line_period, 1056);
    chk("res_locked", mif.locked, 0);

    // inverted waveform, active-high sync
    snap();
    repeat (9) line(1056, 128, 1'b1);
    chk("inv_mv",     mv_total - mv0, 8);
    chk("inv_lo",     lo_total - lo0, 5);
    chk("inv_pol",    mif.sync_pol, 1);
    chk("inv_width",  mif.pulse_width, 128);
    chk("inv_period", mif.line_period, 1056);
    chk("inv_locked", mif.locked, 1);
    chk("inv_ls",     ls_total - ls0, 2);
    chk("inv_ls_lat", ls_cyc - rise_cyc, LAT);

    // 2-clk glitch inside the low phase
    repeat (8) line(1056, 128, 1'b0);
    chk("gl_pre_locked", mif.locked, 1);
    snap();
    drive(1'b0, 60);
    drive(1'b1, 2);
    drive(1'b0, 66);
    drive(1'b1, 928);
    line(1056, 128, 1'b0);
    chk("gl_mv", mv_total - mv0, GL_MV);
    chk("gl_lo", lo_total - lo0, GL_LO);

    // reset mid-line
    drive(1'b0, 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_locked", mif.locked, 0);
    chk("mid_rst_period", mif.line_period, 0);
    chk("mid_rst_nosig",  mif.no_signal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_hsync_monitor.md
Name: vga_hsync_monitor

Overview:
- Receive-side counterpart of the VGA hsync generator: samples an incoming hsync line and measures its line period, sync pulse width and sync polarity.
- Declares lock once the timing is stable.
- Emits a per-line start strobe so downstream capture/overlay logic can align to an external or looped-back video source.
- Sits in the VGA clock domain (40 MHz) and is fed either by the local generator, for self-check, or by an external pin.

Parameters:
- CNT_W, 12, width of all phase/period counters; saturation value is 2^CNT_W-1.
- LOCK_LINES, 4, consecutive matching measurements required before locked asserts.
- TOL, 2, maximum absolute period difference (clocks) that still counts as a match.

Ports:
- clk  in  1  VGA pixel clock
- rst  in  1  asynchronous reset, active-high
- hsync_in  in  1  raw hsync; asynchronous to clk
- line_period  out  CNT_W  last measured period in clocks (high phase + low phase)
- pulse_width  out  CNT_W  last measured length of the shorter phase (the sync pulse)
- sync_pol  out  1  0 = active-low sync, 1 = active-high sync
- meas_valid  out  1  one-cycle strobe when line_period, pulse_width and sync_pol update
- locked  out  1  timing stable
- line_start  out  1  one-cycle strobe on the asserting edge of sync, per current sync_pol
- no_signal  out  1  set on phase-counter timeout; cleared by the next published measurement

Behaviour:
- Reset: all outputs 0; FSM in WAIT_RISE; counters 0; match count 0.
- Input path: 2-FF synchronizer, then 1 edge-detect register. An edge on hsync_in is acted on 3 clk cycles later. For a clk-synchronous input, measured phase lengths equal the true cycle counts exactly.
- FSM:
  - WAIT_RISE: on a rising edge, go to MEAS_HIGH with high_cnt=1.
  - MEAS_HIGH: high_cnt++ per cycle; on a falling edge, go to MEAS_LOW with low_cnt=1.
  - MEAS_LOW: low_cnt++ per cycle; on a rising edge, publish, then go to MEAS_HIGH with high_cnt=1.
- Publish (registered; outputs valid the cycle after the rising edge, together with meas_valid=1):
  - line_period = high_cnt + low_cnt, saturating at 2^CNT_W-1.
  - sync_pol = (high_cnt < low_cnt). Ties give sync_pol=0.
  - pulse_width = min(high_cnt, low_cnt).
- Lock:
  - A publish matches if the previous publish existed since the last reset/timeout, |period - prev_period| <= TOL, and sync_pol is unchanged.
  - Match: match_cnt++ (saturating at LOCK_LINES). Non-match: match_cnt=0 and locked=0 in the same cycle as meas_valid.
  - locked=1 when match_cnt reaches LOCK_LINES. First publish never matches, so lock asserts at publish number LOCK_LINES+1.
- line_start: fires on a falling edge when sync_pol=0 and on a rising edge when sync_pol=1, in the edge-detect cycle, only while locked=1.
- Timeout: if high_cnt or low_cnt reaches 2^CNT_W-1, then in that cycle locked=0, match_cnt=0, no_signal=1, previous measurement discarded, FSM to WAIT_RISE. line_period, pulse_width and sync_pol hold their last values.
- no_signal clears on the next meas_valid.
- Reset mid-line: state discarded immediately; measurement restarts from WAIT_RISE.
- Simultaneous publish and saturation cannot occur, because counters saturate before the sum is formed; the sum itself saturates.

Optional Feature:
- Macro: VGA_HSYNC_MON_DEGLITCH_EN.
- Defined: a 3-cycle stability filter sits after the synchronizer. A level is accepted only after 3 identical consecutive samples, so input pulses shorter than 3 clks are ignored. Edge-to-action latency becomes 5 cycles. Measured phase lengths are unchanged for clean inputs, since both edges are delayed equally.
- Undefined: no filter; latency 3 cycles; every synchronized transition counts.

Test Plan:
- Local generator timing (1056-clk period, low for 128 clks), clk-synchronous, 8 lines:
  - meas_valid fires once per line after the first full line.
  - line_period=1056, pulse_width=128, sync_pol=0.
  - locked rises with the 5th meas_valid.
  - line_start fires once per line, 3 clks after each falling edge, once locked.
- Inverted waveform (high for 128 of 1056) -> sync_pol=1, pulse_width=128, line_period=1056; line_start follows rising edges.
- Locked, then one line at period 1060 -> locked drops with that meas_valid; relocks after 4 more matching 1060-clk lines.
- Period jitter of ±2 clks around 1056 -> locked stays 1; jitter of 3 -> locked drops.
- hsync_in held low for 5000 clks -> no_signal=1 and locked=0 when low_cnt hits 4095; last outputs held; no_signal clears on the next meas_valid after the signal resumes.
- With VGA_HSYNC_MON_DEGLITCH_EN: a 2-clk high glitch inside the low phase leaves line_period=1056. Without the macro, the same glitch produces a split measurement and locked drops.
